// File: rtl/uart_bridge_pkg.sv
// Shared types and constants for the UART register bridge.
// UART_BRIDGE_CHECKSUM_EN adds the GET_CSUM state to the FSM encoding.
package uart_bridge_pkg;

  localparam logic [7:0] OP_WRITE      = 8'h57;
  localparam logic [7:0] OP_READ       = 8'h52;
  localparam logic [7:0] CSUM_ERR_BYTE = 8'h21;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_GET_ADDR   = 4'd1,
    ST_GET_DATA   = 4'd2,
    ST_BUS_WR     = 4'd3,
    ST_BUS_RD     = 4'd4,
    ST_RD_WAIT    = 4'd5,
    ST_TX_SEND    = 4'd6,
    ST_TX_WAIT_HI = 4'd7,
    ST_TX_WAIT_LO = 4'd8
`ifdef UART_BRIDGE_CHECKSUM_EN
    , ST_GET_CSUM = 4'd9
`endif
  } state_e;

endpackage

// File: rtl/uart_bridge_timeout.sv
// Loadable down-counter: reload on i_load, count while i_run, pulse o_expire
// on the first running cycle that finds the count exhausted.
module uart_bridge_timeout #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_run,
  output logic             o_expire
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_run && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // A reload in the same cycle wins over expiry.
  assign o_expire = i_run && !i_load && (r_cnt == '0);

endmodule

// File: rtl/uart_reg_bridge.sv
// UART command-frame decoder driving a byte-wide register bus, one reply byte per frame.
// Optional trailing XOR checksum byte when UART_BRIDGE_CHECKSUM_EN is defined.
module uart_reg_bridge
  import uart_bridge_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 104167,
  parameter logic [7:0] ACK_BYTE       = 8'h4B,
  parameter logic [7:0] NAK_BYTE       = 8'h3F
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       bridge_busy
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e     r_state;
  logic       r_is_write;
  logic [7:0] r_tx_data;
  logic [7:0] r_addr;
  logic [7:0] r_wdata;
`ifdef UART_BRIDGE_CHECKSUM_EN
  logic [7:0] r_csum;
`endif

  logic w_timed;
  logic w_load;
  logic w_expire;

  assign w_timed = (r_state == ST_GET_ADDR) || (r_state == ST_GET_DATA)
`ifdef UART_BRIDGE_CHECKSUM_EN
                   || (r_state == ST_GET_CSUM)
`endif
                   ;
  // Every entry into a timed state is caused by rx_ready, so reloading while idle covers entry.
  assign w_load = rx_ready || !w_timed;

  uart_bridge_timeout #(.CNT_W(CNT_W)) u_timeout (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (LOAD_VAL),
    .i_run      (w_timed),
    .o_expire   (w_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_is_write <= 1'b0;
      r_tx_data  <= 8'h00;
      r_addr     <= 8'h00;
      r_wdata    <= 8'h00;
`ifdef UART_BRIDGE_CHECKSUM_EN
      r_csum     <= 8'h00;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (rx_ready) begin
            if ((rx_data == OP_WRITE) || (rx_data == OP_READ)) begin
              r_is_write <= (rx_data == OP_WRITE);
`ifdef UART_BRIDGE_CHECKSUM_EN
              r_csum     <= rx_data;
`endif
              r_state    <= ST_GET_ADDR;
            end else begin
              r_tx_data <= NAK_BYTE;
              r_state   <= ST_TX_SEND;
            end
          end
        end
        ST_GET_ADDR: begin
          if (rx_ready) begin
            r_addr <= rx_data;
`ifdef UART_BRIDGE_CHECKSUM_EN
            r_csum  <= r_csum ^ rx_data;
            r_state <= r_is_write ? ST_GET_DATA : ST_GET_CSUM;
`else
            r_state <= r_is_write ? ST_GET_DATA : ST_BUS_RD;
`endif
          end else if (w_expire) begin
            r_state <= ST_IDLE;
          end
        end
        ST_GET_DATA: begin
          if (rx_ready) begin
            r_wdata <= rx_data;
`ifdef UART_BRIDGE_CHECKSUM_EN
            r_csum  <= r_csum ^ rx_data;
            r_state <= ST_GET_CSUM;
`else
            r_state <= ST_BUS_WR;
`endif
          end else if (w_expire) begin
            r_state <= ST_IDLE;
          end
        end
`ifdef UART_BRIDGE_CHECKSUM_EN
        ST_GET_CSUM: begin
          if (rx_ready) begin
            if (rx_data == r_csum) begin
              r_state <= r_is_write ? ST_BUS_WR : ST_BUS_RD;
            end else begin
              r_tx_data <= CSUM_ERR_BYTE;
              r_state   <= ST_TX_SEND;
            end
          end else if (w_expire) begin
            r_state <= ST_IDLE;
          end
        end
`endif
        ST_BUS_WR: begin
          r_tx_data <= ACK_BYTE;
          r_state   <= ST_TX_SEND;
        end
        ST_BUS_RD:  r_state <= ST_RD_WAIT;
        // Read data is valid exactly one cycle after the strobe.
        ST_RD_WAIT: begin
          r_tx_data <= reg_rdata;
          r_state   <= ST_TX_SEND;
        end
        ST_TX_SEND:    if (!tx_busy) r_state <= ST_TX_WAIT_HI;
        ST_TX_WAIT_HI: if (tx_busy)  r_state <= ST_TX_WAIT_LO;
        ST_TX_WAIT_LO: if (!tx_busy) r_state <= ST_IDLE;
        default:       r_state <= ST_IDLE;
      endcase
    end
  end

  assign tx_data     = r_tx_data;
  assign reg_addr    = r_addr;
  assign reg_wdata   = r_wdata;
  assign reg_we      = (r_state == ST_BUS_WR);
  assign reg_re      = (r_state == ST_BUS_RD);
  assign tx_start    = (r_state == ST_TX_SEND) && !tx_busy;
  assign bridge_busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Bench for uart_reg_bridge: directed vector table, timing corner sequences and
// random frames against a frame-level model. Honors UART_BRIDGE_CHECKSUM_EN.
module tb_uart_reg_bridge;

  localparam int TO = 100;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       bridge_busy;

  uart_reg_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .reg_we      (reg_we),
    .reg_re      (reg_re),
    .reg_rdata   (reg_rdata),
    .bridge_busy (bridge_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment state (written only by the environment process)
  int         cyc;
  int         n_we, n_re, n_start;
  logic [7:0] we_addr, we_data, re_addr, tx_byte;
  int         tx_cyc;
  logic [7:0] slave_mem [256];
  int         xmit_cnt;
  bit         xmit_req, rd_pend;
  logic [7:0] rd_addr;

  // Stimulus/checker state (written only by the main process)
  bit         force_busy;
  int         last_rx_cyc;
  int         n_checks, n_errors;
  logic [7:0] model_mem [256];

  typedef struct {
    logic [7:0] b0, b1, b2;
    int         n;
    int         gap;
    bit         we;
    bit         re;
    logic [7:0] addr, wdata, resp;
    int         lat;
  } vec_t;
  vec_t vecs [13];

  function automatic logic [7:0] mem_init(input int i);
    return 8'((i * 37 + 11) & 8'hFF);
  endfunction

  // Register slave + transmitter model
  initial begin
    cyc = 0; n_we = 0; n_re = 0; n_start = 0; xmit_cnt = 0;
    xmit_req = 0; rd_pend = 0; rd_addr = 0; tx_cyc = 0;
    we_addr = 0; we_data = 0; re_addr = 0; tx_byte = 0;
    tx_busy = 1'b0; reg_rdata = 8'h00;
    for (int i = 0; i < 256; i++) slave_mem[i] = mem_init(i);
    forever begin
      @(negedge clk);
      if (reg_we) begin
        n_we++; we_addr = reg_addr; we_data = reg_wdata;
        slave_mem[reg_addr] = reg_wdata;
      end
      if (reg_re) begin
        n_re++; re_addr = reg_addr;
      end
      rd_pend = reg_re;
      rd_addr = reg_addr;
      xmit_req = tx_start;
      if (tx_start) begin
        n_start++; tx_byte = tx_data; tx_cyc = cyc;
      end
      @(posedge clk);
      cyc++;
      #1;
      if (xmit_cnt > 0) xmit_cnt--;
      if (xmit_req) xmit_cnt = 20;
      tx_busy = force_busy || (xmit_cnt > 0);
      reg_rdata = rd_pend ? slave_mem[rd_addr] : 8'($urandom);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Called at posedge+1; rx_ready is high for the current cycle only.
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_ready = 1'b1;
    last_rx_cyc = cyc;
    @(posedge clk); #1;
    rx_ready = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!bridge_busy) begin done = 1; break; end
    end
    if (!done) begin
      n_checks++; n_errors++;
      $display("FAIL wait_idle: bridge_busy still 1 after 400 cycles");
    end
    @(posedge clk); #1;
  endtask

  task automatic apply_frame(input logic [7:0] b0, b1, b2, input int n, input int gap,
                             input bit bad, input bit e_we, input bit e_re,
                             input logic [7:0] ea, ed, eresp, input int elat);
    int w0, r0, s0;
    logic [7:0] cs;
    w0 = n_we; r0 = n_re; s0 = n_start;
    send_byte(b0);
    if (n > 1) begin idle(gap); send_byte(b1); end
    if (n > 2) begin idle(gap); send_byte(b2); end
`ifdef UART_BRIDGE_CHECKSUM_EN
    if (n > 1) begin
      cs = b0 ^ b1 ^ ((n > 2) ? b2 : 8'h00);
      if (bad) cs = cs ^ 8'(1 << $urandom_range(0, 7));
      idle(gap);
      send_byte(cs);
    end
`else
    cs = 8'h00;
    if (bad) cs = 8'h01;
`endif
    wait_idle();
    chk("we_count", n_we - w0, {31'd0, e_we});
    if (e_we) begin
      chk("we_addr", we_addr, ea);
      chk("we_data", we_data, ed);
    end
    chk("re_count", n_re - r0, {31'd0, e_re});
    if (e_re) chk("re_addr", re_addr, ea);
    chk("tx_start_count", n_start - s0, 1);
    chk("tx_data", tx_byte, eresp);
    chk("tx_latency", tx_cyc - last_rx_cyc, elat);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_tx_start"}, tx_start, 0);
    chk({tag, "_reg_addr"}, reg_addr, 0);
    chk({tag, "_reg_wdata"}, reg_wdata, 0);
    chk({tag, "_reg_we"}, reg_we, 0);
    chk({tag, "_reg_re"}, reg_re, 0);
    chk({tag, "_bridge_busy"}, bridge_busy, 0);
  endtask

  initial begin
    int w0, s0, r0;
    bit got, bad;
    logic [7:0] a, d, b;
    int k, gap;
    n_checks = 0; n_errors = 0; force_busy = 0; last_rx_cyc = 0;
    rst = 1'b1; rx_data = 8'h00; rx_ready = 1'b0;
    for (int i = 0; i < 256; i++) model_mem[i] = mem_init(i);

    vecs[0]  = '{8'h57, 8'h10, 8'hA5, 3, 0, 1, 0, 8'h10, 8'hA5, 8'h4B, 2};
    vecs[1]  = '{8'h57, 8'h22, 8'h3C, 3, 2, 1, 0, 8'h22, 8'h3C, 8'h4B, 2};
    vecs[2]  = '{8'h52, 8'h22, 8'h00, 2, 0, 0, 1, 8'h22, 8'h00, 8'h3C, 3};
    vecs[3]  = '{8'h00, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00, 8'h3F, 1};
    vecs[4]  = '{8'h57, 8'h01, 8'h02, 3, 1, 1, 0, 8'h01, 8'h02, 8'h4B, 2};
    vecs[5]  = '{8'h52, 8'h01, 8'h00, 2, 3, 0, 1, 8'h01, 8'h00, 8'h02, 3};
    vecs[6]  = '{8'hFF, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00, 8'h3F, 1};
    vecs[7]  = '{8'h57, 8'hFF, 8'h00, 3, 0, 1, 0, 8'hFF, 8'h00, 8'h4B, 2};
    vecs[8]  = '{8'h52, 8'hFF, 8'h00, 2, 0, 0, 1, 8'hFF, 8'h00, 8'h00, 3};
    vecs[9]  = '{8'h57, 8'h00, 8'hFF, 3, 0, 1, 0, 8'h00, 8'hFF, 8'h4B, 2};
    vecs[10] = '{8'h52, 8'h00, 8'h00, 2, 1, 0, 1, 8'h00, 8'h00, 8'hFF, 3};
    vecs[11] = '{8'h77, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00, 8'h3F, 1};
    vecs[12] = '{8'h4B, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00, 8'h3F, 1};

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    idle(2);

    // Directed vector table
    for (int i = 0; i < 13; i++) begin
      apply_frame(vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].n, vecs[i].gap, 1'b0,
                  vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata, vecs[i].resp, vecs[i].lat);
      if (vecs[i].we) model_mem[vecs[i].addr] = vecs[i].wdata;
    end

    // Timeout: partial write frame silently discarded after TO idle cycles
    w0 = n_we; s0 = n_start;
    send_byte(8'h57);
    send_byte(8'h10);
    idle(TO - 1);
    @(negedge clk);
    chk("timeout_busy_last_cycle", bridge_busy, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("timeout_back_idle", bridge_busy, 0);
    @(posedge clk); #1;
    idle(30);
    chk("timeout_no_we", n_we - w0, 0);
    chk("timeout_no_tx", n_start - s0, 0);
    apply_frame(8'h52, 8'h10, 8'h00, 2, 0, 1'b0, 0, 1, 8'h10, 8'h00, model_mem[8'h10], 3);

    // Byte arriving on the expiry cycle is accepted
    send_byte(8'h57);
    send_byte(8'h10);
    idle(TO - 1);
    w0 = n_we;
    send_byte(8'h5C);
`ifdef UART_BRIDGE_CHECKSUM_EN
    send_byte(8'h57 ^ 8'h10 ^ 8'h5C);
`endif
    wait_idle();
    chk("expiry_edge_we", n_we - w0, 1);
    chk("expiry_edge_data", we_data, 8'h5C);
    model_mem[8'h10] = 8'h5C;
    apply_frame(8'h52, 8'h10, 8'h00, 2, 0, 1'b0, 0, 1, 8'h10, 8'h00, 8'h5C, 3);

`ifdef UART_BRIDGE_CHECKSUM_EN
    apply_frame(8'h57, 8'h10, 8'hA5, 3, 0, 1'b0, 1, 0, 8'h10, 8'hA5, 8'h4B, 2);
    model_mem[8'h10] = 8'hA5;
    w0 = n_we;
    send_byte(8'h57); send_byte(8'h10); send_byte(8'hA5); send_byte(8'h00);
    wait_idle();
    chk("csum_bad_no_we", n_we - w0, 0);
    chk("csum_bad_resp", tx_byte, 8'h21);
`endif

    // Transmitter held busy: no tx_start, extra bytes ignored
    force_busy = 1;
    idle(2);
    w0 = n_we; s0 = n_start; r0 = n_re;
    send_byte(8'h57); send_byte(8'h30); send_byte(8'h5A);
`ifdef UART_BRIDGE_CHECKSUM_EN
    send_byte(8'h57 ^ 8'h30 ^ 8'h5A);
`endif
    model_mem[8'h30] = 8'h5A;
    idle(20);
    send_byte(8'h52); send_byte(8'h11); idle(3); send_byte(8'h00);
    idle(480);
    chk("busy_hold_no_start", n_start - s0, 0);
    chk("busy_hold_we", n_we - w0, 1);
    chk("busy_hold_still_busy", bridge_busy, 1);
    force_busy = 0;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (n_start != s0) begin got = 1; break; end
    end
    @(posedge clk); #1;
    chk("busy_release_start", n_start - s0, 1);
    chk("busy_release_data", tx_byte, 8'h4B);
    chk("busy_extra_no_re", n_re - r0, 0);
    chk("busy_extra_no_we", n_we - w0, 1);

    // Reset while waiting for the transmitter to finish
    idle(5);
    chk("pre_rst_busy", bridge_busy, 1);
    #2 rst = 1'b1;
    #1;
    chk_reset_outputs("mid_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    s0 = n_start;
    idle(40);
    chk("post_rst_no_tx", n_start - s0, 0);

    // Random frames against the frame-level model
    for (int it = 0; it < 40; it++) begin
      k = $urandom_range(0, 9);
      gap = $urandom_range(0, 4);
      a = 8'($urandom);
      d = 8'($urandom);
`ifdef UART_BRIDGE_CHECKSUM_EN
      bad = ($urandom_range(0, 7) == 0);
`else
      bad = 0;
`endif
      if (k < 1) begin
        b = 8'($urandom);
        while (b == 8'h57 || b == 8'h52) b = 8'($urandom);
        apply_frame(b, 8'h00, 8'h00, 1, gap, 1'b0, 0, 0, 8'h00, 8'h00, 8'h3F, 1);
      end else if (k < 5) begin
        if (bad) begin
          apply_frame(8'h57, a, d, 3, gap, 1'b1, 0, 0, a, d, 8'h21, 1);
        end else begin
          model_mem[a] = d;
          apply_frame(8'h57, a, d, 3, gap, 1'b0, 1, 0, a, d, 8'h4B, 2);
        end
      end else begin
        if (bad) apply_frame(8'h52, a, 8'h00, 2, gap, 1'b1, 0, 0, a, 8'h00, 8'h21, 1);
        else     apply_frame(8'h52, a, 8'h00, 2, gap, 1'b0, 0, 1, a, 8'h00, model_mem[a], 3);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_reg_bridge.md
Name: uart_reg_bridge

Overview:
- Command responder on the host side of the UART byte interface: consumes received bytes (rx_data/rx_ready), decodes fixed-length command frames and drives a simple register bus.
- Answers each completed frame with one byte through the transmitter handshake (tx_data/tx_start/tx_busy).
- Sits beside uart_top and connects directly to its rx and tx byte ports. Gives an external host read/write access to on-chip control registers.

Parameters:
- TIMEOUT_CYCLES, 104167: idle clocks allowed between bytes of one frame before the partial frame is discarded (about 2 byte times at 50 MHz / 9600 baud). Must be ≥ 1.
- ACK_BYTE, 8'h4B: response byte for a completed write ('K').
- NAK_BYTE, 8'h3F: response byte for an unknown command ('?').

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- rx_data  in  8  received byte, valid when rx_ready=1
- rx_ready  in  1  one-cycle pulse per received byte
- tx_data  out  8  response byte to transmitter
- tx_start  out  1  one-cycle transmit request
- tx_busy  in  1  transmitter busy
- reg_addr  out  8  register bus address
- reg_wdata  out  8  register bus write data
- reg_we  out  1  one-cycle write strobe
- reg_re  out  1  one-cycle read strobe
- reg_rdata  in  8  read data, valid exactly 1 cycle after reg_re
- bridge_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: async assert forces IDLE. tx_data=0, tx_start=0, reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0, bridge_busy=0, timeout counter=0. Reset mid-frame or mid-response abandons the frame; no byte is sent.
- Frames:
  - Write: 8'h57 ('W'), addr, data.
  - Read: 8'h52 ('R'), addr.
- States: IDLE, GET_ADDR, GET_DATA, BUS_WR, BUS_RD, RD_WAIT, TX_SEND, TX_WAIT_HI, TX_WAIT_LO.
- IDLE, on rx_ready:
  - 'W' or 'R': latch the opcode, go to GET_ADDR.
  - Any other byte: tx_data=NAK_BYTE, go to TX_SEND.
- GET_ADDR, on rx_ready: latch reg_addr. Next state is GET_DATA for 'W', BUS_RD for 'R'.
- GET_DATA, on rx_ready: latch reg_wdata, go to BUS_WR.
- BUS_WR: reg_we=1 for exactly one cycle, tx_data=ACK_BYTE, go to TX_SEND.
- BUS_RD: reg_re=1 for exactly one cycle, go to RD_WAIT.
- RD_WAIT: capture reg_rdata into tx_data, go to TX_SEND.
- TX_SEND: wait while tx_busy=1. When tx_busy=0, pulse tx_start for one cycle and go to TX_WAIT_HI.
- TX_WAIT_HI: wait for tx_busy=1, then go to TX_WAIT_LO.
- TX_WAIT_LO: wait for tx_busy=0, then go to IDLE.
- Latency: final frame byte rx_ready → tx_start is 2 cycles for a write and 3 cycles for a read, provided tx_busy=0.
- Timeout:
  - Counter runs only in GET_ADDR and GET_DATA. It clears on every rx_ready and on entering those states.
  - When the count reaches TIMEOUT_CYCLES-1 with no rx_ready, go to IDLE silently: no bus strobe, no response.
  - If rx_ready and expiry fall in the same cycle, the byte is accepted.
- rx_ready while in BUS_*, RD_WAIT or TX_* states: byte dropped, state unaffected.
- Counter width: $clog2(TIMEOUT_CYCLES+1). No wrap is possible because the counter saturates via the state exit.

Optional Feature:
- UART_BRIDGE_CHECKSUM_EN defined:
  - Every W/R frame carries one trailing byte equal to the XOR of all preceding frame bytes, received in added state GET_CSUM (subject to the timeout).
  - Mismatch: no bus strobe; respond 8'h21 ('!').
  - Match: proceed as normal.
- Undefined: GET_CSUM and the XOR accumulator are not compiled; frames are as above.

Decomposition:
- Package uart_bridge_pkg holds:
  - state enum;
  - opcode constants OP_WRITE=8'h57 and OP_READ=8'h52;
  - CSUM_ERR_BYTE=8'h21.
- Sub-module uart_bridge_timeout: loadable down-counter with clear and expire pulse, reusable elsewhere. All other logic stays in one FSM module.

Test Plan:
- Rx 57,10,A5 → reg_we pulse with reg_addr=10, reg_wdata=A5. tx_start comes 2 cycles after the third rx_ready with tx_data=4B.
- Rx 52,22 with reg_rdata=3C on the cycle after reg_re → one reg_re pulse at addr 22, then tx_start with tx_data=3C.
- Rx 00 → tx_data=3F sent. Then rx 57,01,02 → normal write and ACK.
- Rx 57,10, then no byte for TIMEOUT_CYCLES (bench value 100) → return to IDLE, no reg_we, no tx_start. A following 52,10 is handled correctly.
- tx_busy held high for 500 cycles at response time → tx_start stays low until tx_busy falls, then one pulse. Extra rx bytes during the wait are ignored. rst asserted in TX_WAIT_LO → all outputs at reset values immediately.
- (CHECKSUM_EN) Rx 57,10,A5,E2 → write and 4B. Rx 57,10,A5,00 → no write and 21.
